mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter owning a shared 8:1 single-bit mux.
// A requester keeps the grant while its req stays high.
// Releasing the grant costs one IDLE cycle.
// The search pointer then restarts just past the released owner.
// Optional build macro LOCK_TIMEOUT_EN adds a hold counter that force-revokes
// a grant after TIMEOUT cycles and pulses tmo. Without it, tmo is tied low.
module mux8_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       dout,
    output logic       busy,
    output logic       tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] gnt_r;
    logic [7:0] gnt_nxt_s;
    logic [2:0] sel_r;
    logic [2:0] sel_nxt_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;
    logic       any_req_s;
    logic       owner_req_s;
    logic       expire_s;
    logic [2:0] pick_s;

    // First set request bit when scanning ptr, ptr+1, ... ptr+7 (mod 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign any_req_s   = |req;
    assign owner_req_s = req[sel_r];
    assign pick_s      = rr_pick(req, ptr_r);

`ifdef LOCK_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nxt_s;
    logic       tmo_r;

    // Grant has been held for TIMEOUT cycles and the owner still wants it.
    assign expire_s = (state_r == GRANT) && owner_req_s && (hold_cnt_r == HOLD_LAST);

    // Hold counter counts consecutive GRANT cycles, zero otherwise.
    always_comb begin
        hold_cnt_nxt_s = 8'd0;
        if ((state_r == GRANT) && (state_nxt_s == GRANT)) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_nxt_s = 8'd0;
        end
    end

    // Hold counter and one-cycle revoke pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= 8'd0;
            tmo_r      <= 1'b0;
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
            tmo_r      <= expire_s;
        end
    end

    assign tmo = tmo_r;
`else
    assign expire_s = 1'b0;
    assign tmo      = 1'b0;
`endif

    // State and registered output storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= 8'd0;
            sel_r   <= 3'd0;
            ptr_r   <= 3'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state: grant on any request, release when owner drops or times out.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s || expire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the priority pointer.
    always_comb begin
        gnt_nxt_s  = gnt_r;
        sel_nxt_s  = sel_r;
        ptr_nxt_s  = ptr_r;
        busy_nxt_s = busy_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt_nxt_s  = 8'd1 << pick_s;
                    sel_nxt_s  = pick_s;
                    busy_nxt_s = 1'b1;
                end else begin
                    gnt_nxt_s  = 8'd0;
                    busy_nxt_s = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req_s || expire_s) begin
                    gnt_nxt_s  = 8'd0;
                    busy_nxt_s = 1'b0;
                    ptr_nxt_s  = sel_r + 3'd1;
                end else begin
                    gnt_nxt_s  = gnt_r;
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                gnt_nxt_s  = 8'd0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign busy = busy_r;
    assign dout = busy_r ? din[sel_r] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed, scoreboard-based bench for mux8_rr_arbiter.
// When built with LOCK_TIMEOUT_EN, it also exercises the forced-revoke path.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] din = 8'd0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       dout;
    logic       busy;
    logic       tmo;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       tmo;
        logic       dout;
    } exp_t;

    exp_t sb_q[$];

    mux8_rr_arbiter #(.TIMEOUT(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .gnt  (gnt),
        .sel  (sel),
        .dout (dout),
        .busy (busy),
        .tmo  (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".gnt"},  gnt, e.gnt);
        chk({tag, ".sel"},  {5'd0, sel},  {5'd0, e.sel});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        chk({tag, ".tmo"},  {7'd0, tmo},  {7'd0, e.tmo});
        chk({tag, ".dout"}, {7'd0, dout}, {7'd0, e.dout});
        chk({tag, ".onehot"}, {7'd0, (($countones(gnt) <= 1) && (busy || (gnt == 8'd0)))}, 8'd1);
    endtask

    // One clock: drive inputs, queue expected post-edge outputs, compare.
    task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] d,
                       input logic [7:0] eg, input logic [2:0] es, input logic eb, input logic et);
        exp_t e;
        @(negedge clk);
        req    = r;
        din    = d;
        e.gnt  = eg;
        e.sel  = es;
        e.busy = eb;
        e.tmo  = et;
        e.dout = eb ? d[es] : 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            chk_all(tag, e);
        end
    endtask

    // Change din without a clock edge; dout must follow combinationally.
    task automatic din_now(input string tag, input logic [7:0] d, input logic ed);
        din = d;
        #1;
        chk(tag, {7'd0, dout}, {7'd0, ed});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'd0;
        din = 8'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] one;
        logic [2:0] idx;
        exp_t       e0;

        // Reset state, with din all ones to show dout stays low.
        din = 8'hFF;
        @(negedge clk);
        #1;
        e0.gnt = 8'd0; e0.sel = 3'd0; e0.busy = 1'b0; e0.tmo = 1'b0; e0.dout = 1'b0;
        chk_all("reset", e0);
        rst = 1'b0;

        // Basic grant/release, ptr moves to 1.
        cyc("basic_grant",   8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        cyc("basic_release", 8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("ptr1_pick",     8'h03, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
        cyc("ptr1_release",  8'h00, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0);

        // From ptr=0: requests 4 and 7.
        do_reset();
        cyc("r90_grant4",  8'h90, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        cyc("r90_hold4",   8'h90, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        cyc("r90_rel4",    8'h80, 8'h80, 8'h00, 3'd4, 1'b0, 1'b0);
        cyc("r90_grant7",  8'h80, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        cyc("r90_rel7",    8'h00, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0);

        // Fairness: all request, owner drops for one cycle after two grant cycles.
        for (int k = 0; k < 9; k++) begin
            idx = 3'(k % 8);
            one = 8'd1 << idx;
            cyc("fair_grant", 8'hFF, 8'hA5, one, idx, 1'b1, 1'b0);
            cyc("fair_hold",  8'hFF, 8'hA5, one, idx, 1'b1, 1'b0);
            cyc("fair_drop",  8'hFF & ~one, 8'hA5, 8'h00, idx, 1'b0, 1'b0);
        end

        // ptr=1: a short pulse on req[1] during owner 2 is never granted.
        cyc("nomem_grant2", 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
        cyc("nomem_pulse1", 8'h06, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
        cyc("nomem_hold2",  8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
        cyc("nomem_rel2",   8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        cyc("nomem_idle",   8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);

        // Release with new requests pending: idle first, then re-arbitrate from ptr=4.
        cyc("simul_grant3", 8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0);
        cyc("simul_rel3",   8'h21, 8'h20, 8'h00, 3'd3, 1'b0, 1'b0);
        cyc("simul_grant5", 8'h21, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0);

        // Asynchronous reset mid-grant drops the grant before the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        e0.gnt = 8'd0; e0.sel = 3'd0; e0.busy = 1'b0; e0.tmo = 1'b0; e0.dout = 1'b0;
        chk_all("async_rst", e0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_grant0", 8'h21, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);

        // dout follows din of the owner combinationally; zero while idle.
        cyc("dout_rel0",    8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("dout_grant3",  8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        din_now("dout_fall", 8'h00, 1'b0);
        din_now("dout_rise", 8'h08, 1'b1);
        cyc("dout_idle",    8'h00, 8'hFF, 8'h00, 3'd3, 1'b0, 1'b0);
        din_now("dout_idle_ff", 8'hFF, 1'b0);

`ifdef LOCK_TIMEOUT_EN
        // Forced revoke after 16 held cycles, then requester 2 wins.
        do_reset();
        cyc("tmo_grant1", 8'h06, 8'h00, 8'h02, 3'd1, 1'b1, 1'b0);
        repeat (15) cyc("tmo_hold1", 8'h06, 8'h00, 8'h02, 3'd1, 1'b1, 1'b0);
        cyc("tmo_revoke", 8'h06, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1);
        cyc("tmo_grant2", 8'h06, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
